// File: rtl/selector_navegacion.sv
// Five-button cursor for the 3x3 shape grid: sync + debounce + press-edge per button,
// wrap-around navigation, and a confirm/back FSM that freezes the cursor.
module selector_navegacion #(
  parameter int unsigned DEBOUNCE_CNT = 250000,
  parameter int unsigned CNT_W        = 18
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_enter,
  output logic       circulo,
  output logic       cuadrado,
  output logic       triangulo,
  output logic       ovalo,
  output logic       rectangulo,
  output logic       rombo,
  output logic       hexagono,
  output logic       pentagono,
  output logic       estrella,
  output logic       enter,
  output logic [3:0] shape_code,
  output logic       confirm_pulse
);

  localparam int unsigned NumBtn = 5;
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CNT - 1);

  typedef enum logic {StNavegar, StConfirmado} state_e;

  // Bit order: 0 up, 1 down, 2 left, 3 right, 4 enter
  logic [NumBtn-1:0] raw;
  logic [NumBtn-1:0] sync1_q, sync2_q, stable_q, stable_dly_q, press_q;
  logic [CNT_W-1:0]  cnt_q [NumBtn];

  assign raw = {btn_enter, btn_right, btn_left, btn_down, btn_up};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      press_q      <= '0;
      for (int i = 0; i < NumBtn; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q      <= raw;
      sync2_q      <= sync1_q;
      stable_dly_q <= stable_q;
      press_q      <= stable_q & ~stable_dly_q;
      for (int i = 0; i < NumBtn; i++) begin
        if (sync2_q[i] != stable_q[i]) begin
          if (cnt_q[i] == CntLast) begin
            stable_q[i] <= sync2_q[i];
            cnt_q[i]    <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + 1'b1;
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  logic p_up, p_down, p_left, p_right, p_enter;
  assign {p_enter, p_right, p_left, p_down, p_up} = press_q;

  state_e     state_q;
  logic [1:0] row_q, col_q, row_mv, col_mv;
  logic [3:0] code_q, code_mv;
  logic       enter_q, confirm_q;

  // Opposite pulses in the same cycle cancel; orthogonal pulses combine into a diagonal.
  always_comb begin
    row_mv = row_q;
    col_mv = col_q;
    if (p_up && !p_down)         row_mv = (row_q == 2'd0) ? 2'd2 : row_q - 2'd1;
    else if (p_down && !p_up)    row_mv = (row_q == 2'd2) ? 2'd0 : row_q + 2'd1;
    if (p_left && !p_right)      col_mv = (col_q == 2'd0) ? 2'd2 : col_q - 2'd1;
    else if (p_right && !p_left) col_mv = (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
    code_mv = {2'b00, row_mv} * 4'd3 + {2'b00, col_mv};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StNavegar;
      row_q     <= 2'd0;
      col_q     <= 2'd0;
      code_q    <= 4'd0;
      enter_q   <= 1'b0;
      confirm_q <= 1'b0;
    end else begin
      confirm_q <= 1'b0;
      case (state_q)
        StNavegar: begin
          if (p_enter) begin
            state_q   <= StConfirmado;
            enter_q   <= 1'b1;
            confirm_q <= 1'b1;
          end else begin
            row_q  <= row_mv;
            col_q  <= col_mv;
            code_q <= code_mv;
          end
        end
        StConfirmado: begin
          if (p_enter) begin
            state_q <= StNavegar;
            enter_q <= 1'b0;
          end
        end
        default: state_q <= StNavegar;
      endcase
    end
  end

  logic [8:0] sel;
  assign sel = 9'(16'd1 << code_q);

  assign {estrella, pentagono, hexagono, rombo, rectangulo, ovalo, triangulo, cuadrado, circulo} = sel;
  assign enter         = enter_q;
  assign shape_code    = code_q;
  assign confirm_pulse = confirm_q;

endmodule

// File: tb/tb_selector_navegacion.sv
// Randomized + directed bench for selector_navegacion against a sample-window reference model.
module tb_selector_navegacion;

  localparam int unsigned Db   = 4;
  localparam int          MaxC = 8000;
  localparam bit [4:0] BU = 5'd1, BD = 5'd2, BL = 5'd4, BR = 5'd8, BE = 5'd16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] btn = '0;
  logic       circulo, cuadrado, triangulo, ovalo, rectangulo, rombo, hexagono, pentagono;
  logic       estrella, enter, confirm_pulse;
  logic [3:0] shape_code;
  logic [8:0] sel;

  selector_navegacion #(.DEBOUNCE_CNT(Db), .CNT_W(18)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_up(btn[0]), .btn_down(btn[1]), .btn_left(btn[2]), .btn_right(btn[3]),
    .btn_enter(btn[4]),
    .circulo(circulo), .cuadrado(cuadrado), .triangulo(triangulo), .ovalo(ovalo),
    .rectangulo(rectangulo), .rombo(rombo), .hexagono(hexagono), .pentagono(pentagono),
    .estrella(estrella), .enter(enter), .shape_code(shape_code),
    .confirm_pulse(confirm_pulse)
  );

  assign sel = {estrella, pentagono, hexagono, rombo, rectangulo, ovalo, triangulo, cuadrado,
                circulo};

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: a button's accepted level flips once the last Db synchronized samples all
  // disagree with it; a press is a 0->1 change of that level.
  bit [4:0] raw_h [MaxC];
  bit [4:0] stb_h [MaxC];
  int       k = 0;
  int       m_row = 0, m_col = 0;
  bit       m_conf = 0, m_pulse = 0;
  int       pulse_cnt = 0;

  function automatic bit [4:0] raw_at(input int i);
    return (i < 1) ? 5'd0 : raw_h[i];
  endfunction

  function automatic bit [4:0] stb_at(input int i);
    return (i < 1) ? 5'd0 : stb_h[i];
  endfunction

  task automatic model_step();
    bit [4:0] p;
    for (int b = 0; b < 5; b++) begin
      bit s, flip;
      s = stb_at(k - 1)[b];
      flip = 1'b1;
      for (int j = k - 1 - int'(Db); j <= k - 2; j++) if (raw_at(j)[b] == s) flip = 1'b0;
      stb_h[k][b] = flip ? ~s : s;
    end
    p = stb_at(k - 2) & ~stb_at(k - 3);
    m_pulse = 1'b0;
    if (m_conf) begin
      if (p[4]) m_conf = 1'b0;
    end else if (p[4]) begin
      m_conf  = 1'b1;
      m_pulse = 1'b1;
    end else begin
      if (p[0] && !p[1]) m_row = (m_row + 2) % 3;
      if (p[1] && !p[0]) m_row = (m_row + 1) % 3;
      if (p[2] && !p[3]) m_col = (m_col + 2) % 3;
      if (p[3] && !p[2]) m_col = (m_col + 1) % 3;
    end
  endtask

  task automatic compare();
    int code;
    code = m_row * 3 + m_col;
    check_val("shape_code", shape_code, code);
    check_val("onehot", sel, 32'd1 << code);
    check_val("enter", enter, m_conf);
    check_val("confirm_pulse", confirm_pulse, m_pulse);
  endtask

  task automatic tick(input bit [4:0] nb);
    btn = nb;
    @(posedge clk);
    k++;
    if (k >= MaxC) begin
      $display("FAIL history_overflow: got %0d expected < %0d", k, MaxC);
      $fatal(1, "history overflow");
    end
    raw_h[k] = nb;
    @(negedge clk);
    model_step();
    compare();
    pulse_cnt += int'(confirm_pulse);
  endtask

  task automatic press(input bit [4:0] nb, input int len);
    repeat (len) tick(nb);
    repeat (12) tick(5'd0);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    btn = '0;
    #1;
    check_val("rst_code", shape_code, 0);
    check_val("rst_circulo", circulo, 1);
    check_val("rst_onehot", sel, 9'd1);
    check_val("rst_enter", enter, 0);
    check_val("rst_pulse", confirm_pulse, 0);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    m_row = 0; m_col = 0; m_conf = 1'b0; m_pulse = 1'b0;
  endtask

  initial begin
    int hold [5];
    bit [4:0] cur;
    #1;
    check_val("init_code", shape_code, 0);
    check_val("init_circulo", circulo, 1);
    check_val("init_enter", enter, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Short glitch is filtered.
    press(BR, 3);
    check_val("glitch_no_move", shape_code, 0);

    // Exact latency: raw sampled at the first tick, cursor moves on the 8th edge.
    repeat (7) tick(BR);
    check_val("lat_before", shape_code, 0);
    tick(BR);
    check_val("lat_after", shape_code, 1);
    check_val("lat_cuadrado", cuadrado, 1);
    press(BR, 2);
    check_val("after_10", shape_code, 1);

    press(BR, 100);
    check_val("hold_once", shape_code, 2);
    press(BR, 10);
    check_val("wrap_right", shape_code, 0);
    press(BU, 10);
    check_val("wrap_up", shape_code, 6);
    check_val("hexagono", hexagono, 1);
    press(BL, 10);
    check_val("wrap_left", shape_code, 8);
    check_val("estrella", estrella, 1);

    press(BU, 10);
    press(BL, 10);
    check_val("to_center", shape_code, 4);
    press(BU | BD, 10);
    check_val("up_down_cancel", shape_code, 4);
    check_val("rectangulo", rectangulo, 1);

    press(BR, 10);
    check_val("at_rombo", shape_code, 5);
    pulse_cnt = 0;
    press(BE, 10);
    check_val("confirm_enter", enter, 1);
    check_val("confirm_pulses", pulse_cnt, 1);
    press(BL, 10);
    check_val("frozen", shape_code, 5);
    check_val("frozen_rombo", rombo, 1);
    pulse_cnt = 0;
    press(BE, 10);
    check_val("back_enter", enter, 0);
    check_val("back_code", shape_code, 5);
    check_val("back_no_pulse", pulse_cnt, 0);

    // Asynchronous reset mid-debounce.
    repeat (3) tick(BR);
    do_reset();

    press(BD | BR, 10);
    check_val("diagonal", shape_code, 4);
    do_reset();
    press(BE | BD, 10);
    check_val("prio_enter", enter, 1);
    check_val("prio_code", shape_code, 0);
    press(BE, 10);
    check_val("prio_back", enter, 0);

    // Random phase with mixed glitches and real presses.
    cur = '0;
    for (int b = 0; b < 5; b++) hold[b] = $urandom_range(1, 20);
    for (int c = 0; c < 2500; c++) begin
      for (int b = 0; b < 5; b++) begin
        if (hold[b] == 0) begin
          cur[b] = ~cur[b];
          hold[b] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 20);
        end else begin
          hold[b]--;
        end
      end
      tick(cur);
      if (c == 1200) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/selector_navegacion.md
Name: selector_navegacion

Overview:
- Upstream driver of the shape-selection border overlay.
- Turns five raw push-buttons into a cursor on the 3x3 shape grid, with debouncing and press-edge detection.
- Outputs the nine one-hot shape-select lines plus an `enter` level that the overlay consumes directly.
- A confirm/back state machine freezes the selection once the user confirms it.

Parameters:
- DEBOUNCE_CNT, 250000: consecutive stable cycles required before a button change is accepted (5 ms at 50 MHz); use 4 in simulation.
- CNT_W, 18: width of each debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CNT.

Ports:
- clk  in  1  system clock (VGA pixel-domain clock)
- rst_n  in  1  asynchronous active-low reset
- btn_up  in  1  raw button, asynchronous, active-high
- btn_down  in  1  raw button
- btn_left  in  1  raw button
- btn_right  in  1  raw button
- btn_enter  in  1  raw button; in NAVEGAR confirms, in CONFIRMADO cancels (toggle)
- circulo, cuadrado, triangulo, ovalo, rectangulo, rombo, hexagono, pentagono, estrella  out  1 each  one-hot cursor position
- enter  out  1  high while the selection is confirmed
- shape_code  out  4  cursor index 0..8 (row*3+col)
- confirm_pulse  out  1  one-cycle pulse on entry to CONFIRMADO

Behaviour:
- Reset (async, rst_n=0), all values forced immediately:
  - row=0, col=0, so circulo=1 and the other eight selects are 0;
  - shape_code=0, enter=0, confirm_pulse=0, state=NAVEGAR;
  - all synchronizer flops, stable levels and debounce counters are 0.
- Release is used directly (no reset synchronizer).
- Reset mid-debounce or mid-confirm discards all progress.
- Per-button input path:
  - 2-flop synchronizer.
  - Debouncer: if sync != stable, counter increments; if sync == stable, counter clears.
  - When the counter reaches DEBOUNCE_CNT-1 while still differing, stable takes the sync value and the counter clears.
  - A glitch shorter than DEBOUNCE_CNT cycles never changes stable.
  - Press pulse p_x = stable & ~stable_d (registered), high exactly 1 cycle per press; release generates nothing.
  - Latency from raw rise to p_x high: 2 sync + DEBOUNCE_CNT + 1 cycles.
- Grid mapping (row, col):
  - row 0: circulo=(0,0), cuadrado=(0,1), triangulo=(0,2)
  - row 1: ovalo=(1,0), rectangulo=(1,1), rombo=(1,2)
  - row 2: hexagono=(2,0), pentagono=(2,1), estrella=(2,2)
- Output encoding:
  - row and col are 2-bit registers, values 0..2 only; 3 is unreachable.
  - shape_code = row*3+col, registered and updated in the same edge as row/col.
  - The one-hot selects are decoded from the registers; exactly one is high at all times outside reset.
- FSM NAVEGAR (enter=0):
  - p_up: row = (row==0) ? 2 : row-1
  - p_down: row = (row==2) ? 0 : row+1
  - p_left: col = (col==0) ? 2 : col-1
  - p_right: col = (col==2) ? 0 : col+1
  - Wrap-around on every edge of the grid.
  - Simultaneous p_up & p_down: no vertical move. Simultaneous p_left & p_right: no horizontal move.
  - One vertical and one horizontal pulse in the same cycle: both applied (diagonal).
  - p_enter: go to CONFIRMADO and assert confirm_pulse for 1 cycle; any movement pulse in the same cycle is ignored (enter has priority).
  - Cursor changes appear on outputs 1 cycle after the pulse.
- FSM CONFIRMADO (enter=1):
  - Movement pulses are ignored; row/col hold.
  - p_enter returns to NAVEGAR with enter=0 next cycle; cursor unchanged, no confirm_pulse.
- enter is a registered output, equal to (state==CONFIRMADO).
- Buttons held continuously: no auto-repeat, one move per press.

Test Plan:
- Reset: rst_n=0 mid-operation -> circulo=1, shape_code=0, enter=0 immediately, without waiting for a clock.
- Debounce (DEBOUNCE_CNT=4): a 3-cycle btn_right glitch causes no move. A 10-cycle btn_right press moves to cuadrado (code 1) exactly 2+4+1+1 cycles after the rise. Holding it 100 cycles moves only once.
- Wrap: 3 btn_right presses from (0,0) end at circulo. btn_up from (0,0) lands on hexagono (code 6). btn_left then gives estrella (code 8).
- Simultaneous: up+down pressed together from (1,1) -> stays rectangulo. down+right together from (0,0) -> rectangulo (code 4).
- Confirm: btn_enter at rombo (code 5) -> enter=1, confirm_pulse high 1 cycle. A following btn_left leaves rombo selected. A second btn_enter -> enter=0, rombo still selected, no confirm_pulse.
- Priority: btn_enter and btn_down debounced in the same cycle at (0,0) -> enter=1, cursor stays circulo.
